// File: rtl/biriscv_icache_arb_pkg.sv
// Shared definitions for the icache requester arbiter.
//   REQ_FETCH / REQ_AUX : requester ids carried in the tag FIFO
//   arb_tag_t           : per-request tag {id, drop}
package biriscv_icache_arb_pkg;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_AUX   = 1'b1;

    typedef struct packed {
        logic id;    // which requester owns the response
        logic drop;  // response must be swallowed (owner flushed)
    } arb_tag_t;

endpackage

// File: rtl/biriscv_icache_arb_fifo.sv
// In-order tag FIFO for outstanding icache requests.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i/tag_i   : enqueue a tag (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   drop_id_i[n]   : mark every stored entry owned by requester n as drop
//   head_o         : current head tag
//   empty_o/full_o : occupancy flags
module biriscv_icache_arb_fifo
    import biriscv_icache_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  arb_tag_t   tag_i,
    input  logic       pop_i,
    input  logic [1:0] drop_id_i,
    output arb_tag_t   head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    arb_tag_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            // Marking stale slots too is harmless: a push overwrites them.
            for (int i = 0; i < DEPTH; i++)
                if (drop_id_i[mem_q[i].id])
                    mem_q[i].drop <= 1'b1;
            // Push comes last so the caller's drop bit for a same-cycle
            // flush wins over the mark loop.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= tag_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_ok && !pop_ok)
                count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok)
                count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/biriscv_icache_arb.sv
// Two-requester round-robin arbiter in front of the icache.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req0_* (fetch), req1_* (prefetch/debug): rd/pc/priv/flush in,
//                             accept/valid/inst/error/page_fault out
//   icache_*                : request side (rd/pc/priv/flush out, accept in)
//                             and response side (valid/inst/error/pf in)
//   err_unexpected_o        : sticky, response seen with nothing outstanding
module biriscv_icache_arb
    import biriscv_icache_arb_pkg::*;
#(
    parameter int OUTSTANDING   = 2,
    parameter int OUTSTANDING_W = 1
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_rd_i,
    input  logic [31:0] req0_pc_i,
    input  logic [1:0]  req0_priv_i,
    input  logic        req0_flush_i,
    output logic        req0_accept_o,
    output logic        req0_valid_o,
    output logic [63:0] req0_inst_o,
    output logic        req0_error_o,
    output logic        req0_page_fault_o,
    input  logic        req1_rd_i,
    input  logic [31:0] req1_pc_i,
    input  logic [1:0]  req1_priv_i,
    input  logic        req1_flush_i,
    output logic        req1_accept_o,
    output logic        req1_valid_o,
    output logic [63:0] req1_inst_o,
    output logic        req1_error_o,
    output logic        req1_page_fault_o,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    output logic        icache_flush_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        err_unexpected_o
);

    logic [1:0] rd_w;
    logic [1:0] flush_w;
    logic       prio_q;
    logic       lock_q;
    logic       lock_id_q;
    logic       grant;
    logic       accept;
    logic       fifo_empty;
    logic       fifo_full;
    arb_tag_t   head;
    arb_tag_t   push_tag;
    logic       resp_ok;
    logic       err_q;

    assign rd_w    = {req1_rd_i, req0_rd_i};
    assign flush_w = {req1_flush_i, req0_flush_i};

    // A pending unaccepted request keeps its grant so pc/priv stay stable;
    // the owner flushing abandons that request and frees the arbiter.
    always_comb begin
        grant = prio_q;
        if (lock_q && !flush_w[lock_id_q])
            grant = lock_id_q;
        else if (rd_w[prio_q])
            grant = prio_q;
        else if (rd_w[~prio_q])
            grant = ~prio_q;
    end

    assign icache_rd_o    = !rst_i && rd_w[grant] && !fifo_full;
    assign icache_pc_o    = grant ? req1_pc_i   : req0_pc_i;
    assign icache_priv_o  = grant ? req1_priv_i : req0_priv_i;
    assign icache_flush_o = req0_flush_i | req1_flush_i;
    assign accept         = icache_rd_o && icache_accept_i;
    assign req0_accept_o  = accept && (grant == REQ_FETCH);
    assign req1_accept_o  = accept && (grant == REQ_AUX);

    assign push_tag.id   = grant;
    assign push_tag.drop = flush_w[grant];

    biriscv_icache_arb_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (OUTSTANDING_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (accept),
        .tag_i     (push_tag),
        .pop_i     (icache_valid_i),
        .drop_id_i (flush_w),
        .head_o    (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // The head's drop bit only reflects earlier flushes; a flush arriving
    // with the response must suppress it directly.
    assign resp_ok = !rst_i && icache_valid_i && !fifo_empty && !head.drop
                     && !flush_w[head.id];

    assign req0_valid_o      = resp_ok && (head.id == REQ_FETCH);
    assign req1_valid_o      = resp_ok && (head.id == REQ_AUX);
    assign req0_inst_o       = icache_inst_i;
    assign req1_inst_o       = icache_inst_i;
    assign req0_error_o      = icache_error_i;
    assign req1_error_o      = icache_error_i;
    assign req0_page_fault_o = icache_page_fault_i;
    assign req1_page_fault_o = icache_page_fault_i;
    assign err_unexpected_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= REQ_FETCH;
            lock_q    <= 1'b0;
            lock_id_q <= REQ_FETCH;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= icache_rd_o && !icache_accept_i;
            lock_id_q <= grant;
            if (accept)
                prio_q <= ~grant;
            if (icache_valid_i && fifo_empty)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_biriscv_icache_arb.sv
module tb_biriscv_icache_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_rd_i, req0_flush_i, req1_rd_i, req1_flush_i;
    logic [31:0] req0_pc_i, req1_pc_i;
    logic [1:0]  req0_priv_i, req1_priv_i;
    logic        req0_accept_o, req0_valid_o, req0_error_o, req0_page_fault_o;
    logic        req1_accept_o, req1_valid_o, req1_error_o, req1_page_fault_o;
    logic [63:0] req0_inst_o, req1_inst_o;
    logic        icache_rd_o, icache_flush_o, icache_accept_i;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_valid_i, icache_error_i, icache_page_fault_i;
    logic [63:0] icache_inst_i;
    logic        err_unexpected_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    biriscv_icache_arb dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_rd_i(req0_rd_i), .req0_pc_i(req0_pc_i), .req0_priv_i(req0_priv_i),
        .req0_flush_i(req0_flush_i), .req0_accept_o(req0_accept_o),
        .req0_valid_o(req0_valid_o), .req0_inst_o(req0_inst_o),
        .req0_error_o(req0_error_o), .req0_page_fault_o(req0_page_fault_o),
        .req1_rd_i(req1_rd_i), .req1_pc_i(req1_pc_i), .req1_priv_i(req1_priv_i),
        .req1_flush_i(req1_flush_i), .req1_accept_o(req1_accept_o),
        .req1_valid_o(req1_valid_o), .req1_inst_o(req1_inst_o),
        .req1_error_o(req1_error_o), .req1_page_fault_o(req1_page_fault_o),
        .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o),
        .icache_priv_o(icache_priv_o), .icache_flush_o(icache_flush_o),
        .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
        .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
        .icache_page_fault_i(icache_page_fault_i),
        .err_unexpected_o(err_unexpected_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        req0_rd_i = 1'b1; req0_pc_i = 32'h0000_1000; req0_priv_i = 2'd3; req0_flush_i = 1'b0;
        req1_rd_i = 1'b1; req1_pc_i = 32'h0000_2000; req1_priv_i = 2'd1; req1_flush_i = 1'b0;
        icache_accept_i = 1'b1; icache_valid_i = 1'b0; icache_inst_i = '0;
        icache_error_i = 1'b0; icache_page_fault_i = 1'b0;
        #1;
        chk("rst_rd_low", icache_rd_o, 1'b0);
        chk("rst_acc0_low", req0_accept_o, 1'b0);
        step(); step();
        chk("rst_rd_low2", icache_rd_o, 1'b0);
        chk("rst_err_clear", err_unexpected_o, 1'b0);

        // Both requesting from reset: fetch first, then aux.
        rst_i = 1'b0; #1;
        chk("rr1_rd", icache_rd_o, 1'b1);
        chk("rr1_pc", icache_pc_o, 32'h0000_1000);
        chk("rr1_priv", icache_priv_o, 2'd3);
        chk("rr1_acc0", req0_accept_o, 1'b1);
        chk("rr1_acc1", req1_accept_o, 1'b0);
        step();
        chk("rr2_acc0", req0_accept_o, 1'b0);
        chk("rr2_acc1", req1_accept_o, 1'b1);
        chk("rr2_pc", icache_pc_o, 32'h0000_2000);
        step();
        req0_rd_i = 1'b0; req1_rd_i = 1'b0;
        icache_valid_i = 1'b1; icache_inst_i = 64'h11; icache_error_i = 1'b1; #1;
        chk("resp11_v0", req0_valid_o, 1'b1);
        chk("resp11_v1", req1_valid_o, 1'b0);
        chk("resp11_inst", req0_inst_o, 64'h11);
        chk("resp11_err", req0_error_o, 1'b1);
        step();
        icache_inst_i = 64'h22; icache_error_i = 1'b0; #1;
        chk("resp22_v0", req0_valid_o, 1'b0);
        chk("resp22_v1", req1_valid_o, 1'b1);
        chk("resp22_inst", req1_inst_o, 64'h22);
        step();
        icache_valid_i = 1'b0; #1;
        chk("no_err_yet", err_unexpected_o, 1'b0);

        // Grant lock: aux request held off by icache for three cycles.
        req1_rd_i = 1'b1; req1_pc_i = 32'h8000_0100; icache_accept_i = 1'b0; #1;
        chk("lock_a_pc", icache_pc_o, 32'h8000_0100);
        chk("lock_a_rd", icache_rd_o, 1'b1);
        step();
        req0_rd_i = 1'b1; req0_pc_i = 32'h0000_1234; #1;
        chk("lock_b_pc", icache_pc_o, 32'h8000_0100);
        chk("lock_b_acc1", req1_accept_o, 1'b0);
        step();
        chk("lock_c_pc", icache_pc_o, 32'h8000_0100);
        chk("lock_c_acc0", req0_accept_o, 1'b0);
        step();
        icache_accept_i = 1'b1; #1;
        chk("lock_d_pc", icache_pc_o, 32'h8000_0100);
        chk("lock_d_acc1", req1_accept_o, 1'b1);
        chk("lock_d_acc0", req0_accept_o, 1'b0);
        step();
        req1_rd_i = 1'b0; #1;
        chk("after_lock_acc0", req0_accept_o, 1'b1);
        chk("after_lock_pc", icache_pc_o, 32'h0000_1234);
        step();
        req0_rd_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 64'h33; #1;
        chk("resp33_v1", req1_valid_o, 1'b1);
        chk("resp33_v0", req0_valid_o, 1'b0);
        step();
        icache_inst_i = 64'h44; #1;
        chk("resp44_v0", req0_valid_o, 1'b1);
        step();
        icache_valid_i = 1'b0;

        // FIFO full blocks issue, including the cycle of the pop.
        req0_rd_i = 1'b1; req0_pc_i = 32'h0000_3000; #1;
        chk("full_acc0a", req0_accept_o, 1'b1);
        step();
        chk("full_acc0b", req0_accept_o, 1'b1);
        step();
        req0_rd_i = 1'b0; req1_rd_i = 1'b1; req1_pc_i = 32'h0000_4000; #1;
        chk("full_rd_a", icache_rd_o, 1'b0);
        chk("full_acc1_a", req1_accept_o, 1'b0);
        step();
        chk("full_rd_b", icache_rd_o, 1'b0);
        icache_valid_i = 1'b1; icache_inst_i = 64'h55; #1;
        chk("full_pop_v0", req0_valid_o, 1'b1);
        chk("full_pop_rd", icache_rd_o, 1'b0);
        step();
        icache_valid_i = 1'b0; #1;
        chk("resume_rd", icache_rd_o, 1'b1);
        chk("resume_acc1", req1_accept_o, 1'b1);
        chk("resume_pc", icache_pc_o, 32'h0000_4000);
        step();
        req1_rd_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 64'h66; #1;
        chk("resp66_v0", req0_valid_o, 1'b1);
        step();
        icache_inst_i = 64'h77; #1;
        chk("resp77_v1", req1_valid_o, 1'b1);
        chk("resp77_v0", req0_valid_o, 1'b0);
        step();
        icache_valid_i = 1'b0;

        // Flush of two outstanding fetches drops both responses.
        req0_rd_i = 1'b1; #1;
        chk("fl_acc0a", req0_accept_o, 1'b1);
        step();
        chk("fl_acc0b", req0_accept_o, 1'b1);
        step();
        req0_rd_i = 1'b0; req0_flush_i = 1'b1; #1;
        chk("fl_icache_flush", icache_flush_o, 1'b1);
        step();
        req0_flush_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 64'hAA; #1;
        chk("fl_drop1_v0", req0_valid_o, 1'b0);
        chk("fl_drop1_v1", req1_valid_o, 1'b0);
        step();
        #1;
        chk("fl_drop2_v0", req0_valid_o, 1'b0);
        chk("fl_drop2_v1", req1_valid_o, 1'b0);
        step();
        icache_valid_i = 1'b0; req0_rd_i = 1'b1; #1;
        chk("fl_next_acc0", req0_accept_o, 1'b1);
        step();
        req0_rd_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 64'h88; #1;
        chk("fl_next_v0", req0_valid_o, 1'b1);
        chk("fl_next_inst", req0_inst_o, 64'h88);
        step();
        icache_valid_i = 1'b0;
        chk("fl_no_err", err_unexpected_o, 1'b0);

        // Flush in the same cycle as the accept.
        req0_rd_i = 1'b1; req0_flush_i = 1'b1; #1;
        chk("same_acc0", req0_accept_o, 1'b1);
        chk("same_icache_flush", icache_flush_o, 1'b1);
        step();
        req0_rd_i = 1'b0; req0_flush_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 64'h99; #1;
        chk("same_drop_v0", req0_valid_o, 1'b0);
        chk("same_flush_off", icache_flush_o, 1'b0);
        step();
        icache_valid_i = 1'b0; #1;
        chk("same_no_err", err_unexpected_o, 1'b0);

        // Unexpected response with nothing outstanding.
        icache_valid_i = 1'b1; icache_inst_i = 64'hEE; #1;
        chk("unexp_v0", req0_valid_o, 1'b0);
        chk("unexp_v1", req1_valid_o, 1'b0);
        step();
        icache_valid_i = 1'b0; #1;
        chk("unexp_err_set", err_unexpected_o, 1'b1);
        step(); step();
        chk("unexp_err_sticky", err_unexpected_o, 1'b1);
        rst_i = 1'b1;
        step();
        chk("unexp_err_cleared", err_unexpected_o, 1'b0);

        // Reset mid-operation discards the outstanding request.
        rst_i = 1'b0; req0_rd_i = 1'b1; #1;
        chk("mid_acc0", req0_accept_o, 1'b1);
        step();
        req0_rd_i = 1'b0; rst_i = 1'b1; #1;
        chk("mid_rst_rd", icache_rd_o, 1'b0);
        step();
        rst_i = 1'b0; icache_valid_i = 1'b1; #1;
        chk("mid_resp_v0", req0_valid_o, 1'b0);
        step();
        icache_valid_i = 1'b0; #1;
        chk("mid_err", err_unexpected_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
